// File: rtl/initiator_port_if.sv
// Bundle of the initiator-side handshake and the serial bus signals of initiator_port.
// The master modport is the port's own view; the slave modport is the view of the
// initiator core plus arbiter/target side that drives the inputs.
interface initiator_port_if;
  logic        init_req;
  logic [15:0] init_addr;
  logic [7:0]  init_wdata;
  logic        init_rw;
  logic        init_busy;
  logic        init_done;
  logic        init_error;
  logic [7:0]  init_rdata;
  logic        init_rdata_valid;
  logic        bus_req;
  logic        bus_grant;
  logic        bus_data_out;
  logic        bus_data_out_valid;
  logic        bus_mode;
  logic        bus_init_rw;
  logic        bus_data_in;
  logic        bus_data_in_valid;
  logic        bus_target_ack;

  modport master (
    input  init_req, init_addr, init_wdata, init_rw,
    input  bus_grant, bus_data_in, bus_data_in_valid, bus_target_ack,
    output init_busy, init_done, init_error, init_rdata, init_rdata_valid,
    output bus_req, bus_data_out, bus_data_out_valid, bus_mode, bus_init_rw
  );

  modport slave (
    output init_req, init_addr, init_wdata, init_rw,
    output bus_grant, bus_data_in, bus_data_in_valid, bus_target_ack,
    input  init_busy, init_done, init_error, init_rdata, init_rdata_valid,
    input  bus_req, bus_data_out, bus_data_out_valid, bus_mode, bus_init_rw
  );
endinterface

// File: rtl/initiator_port.sv
// Initiator-side serial bus port. Latches one parallel transaction, requests the bus,
// shifts the address then write data out LSB-first, and for reads collects the
// target's 8-bit reply. Every output is a flop loaded from the decode of the next
// state, so the bus and initiator see glitch-free signals one cycle after each decision.
module initiator_port #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  initiator_port_if.master port
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_WDATA,
    S_WAIT_ACK,
    S_RDATA,
    S_DONE
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [7:0]  rbuf_q, rbuf_d;

  logic        done_err;
  logic        done_rd_ok;

  logic        init_busy_q, init_busy_d;
  logic        init_done_q, init_done_d;
  logic        init_error_q, init_error_d;
  logic [7:0]  init_rdata_q, init_rdata_d;
  logic        init_rdata_valid_q, init_rdata_valid_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_data_out_q, bus_data_out_d;
  logic        bus_data_out_valid_q, bus_data_out_valid_d;
  logic        bus_mode_q, bus_mode_d;
  logic        bus_init_rw_q, bus_init_rw_d;

  // Transaction sequencing: accept, arbitration, serialization, ack/read wait, completion.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    rbuf_d       = rbuf_q;
    init_rdata_d = init_rdata_q;
    done_err     = 1'b0;
    done_rd_ok   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (port.init_req) begin
          addr_d  = port.init_addr;
          wdata_d = port.init_wdata;
          rw_d    = port.init_rw;
          cnt_d   = 4'd0;
          tmo_d   = 8'd0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (port.bus_grant) begin
          cnt_d   = 4'd0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (!port.bus_grant) begin
          done_err = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          tmo_d   = 8'd0;
          rbuf_d  = 8'h00;
          state_d = rw_q ? S_WDATA : S_RDATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WDATA: begin
        if (!port.bus_grant) begin
          done_err = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == 4'd7) begin
          cnt_d   = 4'd0;
          tmo_d   = 8'd0;
          state_d = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // An ack arriving together with grant loss still completes the write.
      S_WAIT_ACK: begin
        if (port.bus_target_ack) begin
          state_d = S_DONE;
        end else if (!port.bus_grant || (tmo_q == TMO_LIMIT)) begin
          done_err = 1'b1;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      // Grant loss outranks a read bit arriving in the same cycle.
      S_RDATA: begin
        if (!port.bus_grant) begin
          done_err = 1'b1;
          state_d  = S_DONE;
        end else if (port.bus_data_in_valid) begin
          rbuf_d[cnt_q[2:0]] = port.bus_data_in;
          tmo_d              = 8'd0;
          if (cnt_q == 4'd7) begin
            init_rdata_d = rbuf_d;
            done_rd_ok   = 1'b1;
            cnt_d        = 4'd0;
            state_d      = S_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_LIMIT) begin
          done_err = 1'b1;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state and counter, loaded into the output flops.
  always_comb begin
    init_busy_d          = (state_d != S_IDLE);
    init_done_d          = (state_d == S_DONE);
    init_error_d         = done_err;
    init_rdata_valid_d   = done_rd_ok;
    bus_req_d            = (state_d == S_REQ) || (state_d == S_ADDR) || (state_d == S_WDATA) ||
                           (state_d == S_WAIT_ACK) || (state_d == S_RDATA);
    bus_data_out_valid_d = (state_d == S_ADDR) || (state_d == S_WDATA);
    bus_mode_d           = (state_d == S_WDATA) || (state_d == S_WAIT_ACK) ||
                           (state_d == S_RDATA) || (state_d == S_DONE);
    bus_init_rw_d        = bus_req_d ? rw_d : 1'b0;
    bus_data_out_d       = 1'b0;
    if (state_d == S_ADDR) begin
      bus_data_out_d = addr_q[cnt_d];
    end else if (state_d == S_WDATA) begin
      bus_data_out_d = wdata_q[cnt_d[2:0]];
    end
  end

  // State, counters, latched transaction and registered outputs; reset discards everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= S_IDLE;
      cnt_q                <= 4'd0;
      tmo_q                <= 8'd0;
      addr_q               <= 16'h0000;
      wdata_q              <= 8'h00;
      rw_q                 <= 1'b0;
      rbuf_q               <= 8'h00;
      init_busy_q          <= 1'b0;
      init_done_q          <= 1'b0;
      init_error_q         <= 1'b0;
      init_rdata_q         <= 8'h00;
      init_rdata_valid_q   <= 1'b0;
      bus_req_q            <= 1'b0;
      bus_data_out_q       <= 1'b0;
      bus_data_out_valid_q <= 1'b0;
      bus_mode_q           <= 1'b0;
      bus_init_rw_q        <= 1'b0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      tmo_q                <= tmo_d;
      addr_q               <= addr_d;
      wdata_q              <= wdata_d;
      rw_q                 <= rw_d;
      rbuf_q               <= rbuf_d;
      init_busy_q          <= init_busy_d;
      init_done_q          <= init_done_d;
      init_error_q         <= init_error_d;
      init_rdata_q         <= init_rdata_d;
      init_rdata_valid_q   <= init_rdata_valid_d;
      bus_req_q            <= bus_req_d;
      bus_data_out_q       <= bus_data_out_d;
      bus_data_out_valid_q <= bus_data_out_valid_d;
      bus_mode_q           <= bus_mode_d;
      bus_init_rw_q        <= bus_init_rw_d;
    end
  end

  assign port.init_busy          = init_busy_q;
  assign port.init_done          = init_done_q;
  assign port.init_error         = init_error_q;
  assign port.init_rdata         = init_rdata_q;
  assign port.init_rdata_valid   = init_rdata_valid_q;
  assign port.bus_req            = bus_req_q;
  assign port.bus_data_out       = bus_data_out_q;
  assign port.bus_data_out_valid = bus_data_out_valid_q;
  assign port.bus_mode           = bus_mode_q;
  assign port.bus_init_rw        = bus_init_rw_q;

endmodule

// File: tb/tb_initiator_port.sv
// Directed testbench for initiator_port with TIMEOUT=4: write, gapped read, ack timeout,
// delayed grant with an ignored second request, grant loss, async reset, back-to-back accept.
module tb_initiator_port;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [15:0] exp_word;
  logic [7:0]  exp_byte;

  initiator_port_if bus_if ();

  initiator_port #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus_if)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; observe and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a transaction request to the port.
  task automatic apply_stimulus(input logic req, input logic [15:0] addr,
                                input logic [7:0] wdata, input logic rw);
    bus_if.init_req   = req;
    bus_if.init_addr  = addr;
    bus_if.init_wdata = wdata;
    bus_if.init_rw    = rw;
  endtask

  // Single-bit comparison.
  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Byte comparison.
  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Every output at its reset value.
  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"},   bus_if.init_busy, 1'b0);
    check_output({tag, "_done"},   bus_if.init_done, 1'b0);
    check_output({tag, "_error"},  bus_if.init_error, 1'b0);
    check_byte  ({tag, "_rdata"},  bus_if.init_rdata, 8'h00);
    check_output({tag, "_rvalid"}, bus_if.init_rdata_valid, 1'b0);
    check_output({tag, "_req"},    bus_if.bus_req, 1'b0);
    check_output({tag, "_dout"},   bus_if.bus_data_out, 1'b0);
    check_output({tag, "_dvalid"}, bus_if.bus_data_out_valid, 1'b0);
    check_output({tag, "_mode"},   bus_if.bus_mode, 1'b0);
    check_output({tag, "_rw"},     bus_if.bus_init_rw, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    bus_if.bus_grant         = 1'b0;
    bus_if.bus_data_in       = 1'b0;
    bus_if.bus_data_in_valid = 1'b0;
    bus_if.bus_target_ack    = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- Write 0x1234 / 0xA5, immediate grant, ack in the third WAIT_ACK cycle ----
    $display("[TB] write 0x1234/0xA5");
    apply_stimulus(1'b1, 16'h1234, 8'hA5, 1'b1);
    bus_if.bus_grant = 1'b1;
    tick();
    check_output("t1_req_bus_req", bus_if.bus_req, 1'b1);
    check_output("t1_req_rw", bus_if.bus_init_rw, 1'b1);
    check_output("t1_req_busy", bus_if.init_busy, 1'b1);
    check_output("t1_req_valid", bus_if.bus_data_out_valid, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    exp_word = 16'b0001_0010_0011_0100;
    for (int k = 0; k < 16; k++) begin
      check_output($sformatf("t1_addr%0d", k), bus_if.bus_data_out, exp_word[k]);
      check_output($sformatf("t1_addr%0d_valid", k), bus_if.bus_data_out_valid, 1'b1);
      check_output($sformatf("t1_addr%0d_mode", k), bus_if.bus_mode, 1'b0);
      tick();
    end
    exp_byte = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      check_output($sformatf("t1_wdata%0d", k), bus_if.bus_data_out, exp_byte[k]);
      check_output($sformatf("t1_wdata%0d_valid", k), bus_if.bus_data_out_valid, 1'b1);
      check_output($sformatf("t1_wdata%0d_mode", k), bus_if.bus_mode, 1'b1);
      tick();
    end
    check_output("t1_wait_valid", bus_if.bus_data_out_valid, 1'b0);
    check_output("t1_wait_dout", bus_if.bus_data_out, 1'b0);
    check_output("t1_wait_mode", bus_if.bus_mode, 1'b1);
    check_output("t1_wait_done", bus_if.init_done, 1'b0);
    tick();
    tick();
    bus_if.bus_target_ack = 1'b1;
    tick();
    bus_if.bus_target_ack = 1'b0;
    check_output("t1_done", bus_if.init_done, 1'b1);
    check_output("t1_done_error", bus_if.init_error, 1'b0);
    check_output("t1_done_bus_req", bus_if.bus_req, 1'b0);
    check_output("t1_done_rvalid", bus_if.init_rdata_valid, 1'b0);
    check_output("t1_done_mode", bus_if.bus_mode, 1'b1);
    tick();
    check_output("t1_idle_done", bus_if.init_done, 1'b0);
    check_output("t1_idle_busy", bus_if.init_busy, 1'b0);
    check_output("t1_idle_mode", bus_if.bus_mode, 1'b0);

    // ---- Read 0x00F0, target returns 0x3C with 2-cycle gaps between bits ----
    $display("[TB] read 0x00F0 -> 0x3C");
    apply_stimulus(1'b1, 16'h00F0, 8'h00, 1'b0);
    tick();
    check_output("t2_req_bus_req", bus_if.bus_req, 1'b1);
    check_output("t2_req_rw", bus_if.bus_init_rw, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    exp_word = 16'h00F0;
    for (int k = 0; k < 16; k++) begin
      check_output($sformatf("t2_addr%0d", k), bus_if.bus_data_out, exp_word[k]);
      tick();
    end
    check_output("t2_rd_valid", bus_if.bus_data_out_valid, 1'b0);
    check_output("t2_rd_mode", bus_if.bus_mode, 1'b1);
    check_output("t2_rd_bus_req", bus_if.bus_req, 1'b1);
    exp_byte = 8'h3C;
    for (int j = 0; j < 8; j++) begin
      tick();
      tick();
      bus_if.bus_data_in_valid = 1'b1;
      bus_if.bus_data_in       = exp_byte[j];
      tick();
      bus_if.bus_data_in_valid = 1'b0;
      bus_if.bus_data_in       = 1'b0;
      if (j == 3) begin
        check_byte("t2_rdata_held", bus_if.init_rdata, 8'h00);
        check_output("t2_mid_done", bus_if.init_done, 1'b0);
      end
    end
    check_output("t2_done", bus_if.init_done, 1'b1);
    check_output("t2_done_rvalid", bus_if.init_rdata_valid, 1'b1);
    check_output("t2_done_error", bus_if.init_error, 1'b0);
    check_byte("t2_done_rdata", bus_if.init_rdata, 8'h3C);
    tick();
    check_output("t2_idle_rvalid", bus_if.init_rdata_valid, 1'b0);
    check_byte("t2_idle_rdata", bus_if.init_rdata, 8'h3C);

    // ---- Write with no ack: error exactly 5 cycles after WAIT_ACK entry ----
    $display("[TB] write ack timeout");
    apply_stimulus(1'b1, 16'h0F0F, 8'h5A, 1'b1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    repeat (24) tick();
    check_output("t3_wait0_valid", bus_if.bus_data_out_valid, 1'b0);
    check_output("t3_wait0_done", bus_if.init_done, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_output($sformatf("t3_wait%0d_done", i), bus_if.init_done, 1'b0);
    end
    tick();
    check_output("t3_done", bus_if.init_done, 1'b1);
    check_output("t3_done_error", bus_if.init_error, 1'b1);
    check_output("t3_done_bus_req", bus_if.bus_req, 1'b0);
    check_output("t3_done_rvalid", bus_if.init_rdata_valid, 1'b0);
    tick();

    // ---- Grant delayed, second request ignored; ack and grant loss together ----
    $display("[TB] delayed grant");
    bus_if.bus_grant = 1'b0;
    apply_stimulus(1'b1, 16'hBEEF, 8'h3C, 1'b1);
    tick();
    for (int c = 0; c < 10; c++) begin
      check_output($sformatf("t4_req%0d_bus_req", c), bus_if.bus_req, 1'b1);
      check_output($sformatf("t4_req%0d_valid", c), bus_if.bus_data_out_valid, 1'b0);
      if (c == 3) apply_stimulus(1'b1, 16'h1111, 8'h00, 1'b0);
      else        apply_stimulus(1'b0, 16'h1111, 8'h00, 1'b0);
      tick();
    end
    bus_if.bus_grant = 1'b1;
    tick();
    exp_word = 16'hBEEF;
    for (int k = 0; k < 16; k++) begin
      check_output($sformatf("t4_addr%0d", k), bus_if.bus_data_out, exp_word[k]);
      tick();
    end
    exp_byte = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      check_output($sformatf("t4_wdata%0d", k), bus_if.bus_data_out, exp_byte[k]);
      tick();
    end
    bus_if.bus_target_ack = 1'b1;
    bus_if.bus_grant      = 1'b0;
    tick();
    bus_if.bus_target_ack = 1'b0;
    bus_if.bus_grant      = 1'b1;
    check_output("t4_done", bus_if.init_done, 1'b1);
    check_output("t4_done_error", bus_if.init_error, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("t4_after%0d_busy", i), bus_if.init_busy, 1'b0);
      check_output($sformatf("t4_after%0d_bus_req", i), bus_if.bus_req, 1'b0);
      tick();
    end

    // ---- Grant dropped at address bit 7 ----
    $display("[TB] grant loss in address phase");
    apply_stimulus(1'b1, 16'hFFFF, 8'h00, 1'b0);
    tick();
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    repeat (7) tick();
    check_output("t5_bit7", bus_if.bus_data_out, 1'b1);
    check_output("t5_bit7_valid", bus_if.bus_data_out_valid, 1'b1);
    bus_if.bus_grant = 1'b0;
    tick();
    check_output("t5_done_valid", bus_if.bus_data_out_valid, 1'b0);
    check_output("t5_done_dout", bus_if.bus_data_out, 1'b0);
    check_output("t5_done", bus_if.init_done, 1'b1);
    check_output("t5_done_error", bus_if.init_error, 1'b1);
    check_output("t5_done_bus_req", bus_if.bus_req, 1'b0);
    bus_if.bus_grant = 1'b1;
    tick();
    check_output("t5_idle_busy", bus_if.init_busy, 1'b0);

    // ---- Reset during WDATA bit 3, then a clean read of 0x0001 ----
    $display("[TB] reset mid-write");
    apply_stimulus(1'b1, 16'h00AA, 8'hFF, 1'b1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    repeat (19) tick();
    check_output("t6_wbit3", bus_if.bus_data_out, 1'b1);
    check_output("t6_wbit3_valid", bus_if.bus_data_out_valid, 1'b1);
    check_output("t6_wbit3_mode", bus_if.bus_mode, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_output("t6_post_done", bus_if.init_done, 1'b0);
    check_output("t6_post_busy", bus_if.init_busy, 1'b0);
    apply_stimulus(1'b1, 16'h0001, 8'h00, 1'b0);
    tick();
    check_output("t6_req_bus_req", bus_if.bus_req, 1'b1);
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    tick();
    exp_word = 16'h0001;
    for (int k = 0; k < 16; k++) begin
      check_output($sformatf("t6_addr%0d", k), bus_if.bus_data_out, exp_word[k]);
      tick();
    end
    exp_byte = 8'h96;
    for (int j = 0; j < 8; j++) begin
      bus_if.bus_data_in_valid = 1'b1;
      bus_if.bus_data_in       = exp_byte[j];
      tick();
    end
    bus_if.bus_data_in_valid = 1'b0;
    bus_if.bus_data_in       = 1'b0;
    check_output("t6_done", bus_if.init_done, 1'b1);
    check_output("t6_done_rvalid", bus_if.init_rdata_valid, 1'b1);
    check_output("t6_done_error", bus_if.init_error, 1'b0);
    check_byte("t6_done_rdata", bus_if.init_rdata, 8'h96);

    // ---- Back-to-back: request held through DONE is accepted in the following IDLE ----
    apply_stimulus(1'b1, 16'h4321, 8'h00, 1'b1);
    tick();
    check_output("t7_idle_bus_req", bus_if.bus_req, 1'b0);
    check_output("t7_idle_busy", bus_if.init_busy, 1'b0);
    tick();
    apply_stimulus(1'b0, 16'h0000, 8'h00, 1'b0);
    check_output("t7_req_bus_req", bus_if.bus_req, 1'b1);
    check_output("t7_req_rw", bus_if.bus_init_rw, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/initiator_port.md
# initiator_port

Initiator-side serial bus port: the counterpart of the target port. Accepts one parallel transaction (16-bit address, 8-bit write data, read/write flag) from a local initiator, requests the bus from the arbiter, serializes address then write data LSB-first onto the one-bit bus, and for reads deserializes the target's 8-bit response. Reports completion, read data and timeout/abort errors back to the initiator. Sits between an initiator core and the bus arbiter/mux.

## Interface
- TIMEOUT, 64: max idle cycles waiting for ack (write) or for the next read bit (read); range 1..255.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_req  in  1  transaction request; sampled only in IDLE.
- init_addr  in  16  target address; latched on accept.
- init_wdata  in  8  write data; latched on accept.
- init_rw  in  1  1 = write, 0 = read; latched on accept.
- init_busy  out  1  high in every state except IDLE.
- init_done  out  1  one-cycle completion pulse (success or error).
- init_error  out  1  high with init_done when the transaction timed out or lost grant.
- init_rdata  out  8  read data; holds until the next read completes.
- init_rdata_valid  out  1  one-cycle pulse with init_done on a successful read.
- bus_req  out  1  arbiter request.
- bus_grant  in  1  arbiter grant.
- bus_data_out  out  1  serial data to target.
- bus_data_out_valid  out  1  bus_data_out qualifier.
- bus_mode  out  1  0 = address phase, 1 = data phase.
- bus_init_rw  out  1  latched rw, driven while bus_req is high, else 0.
- bus_data_in  in  1  serial read data from target.
- bus_data_in_valid  in  1  bus_data_in qualifier.
- bus_target_ack  in  1  target acknowledge of a write.

## Operation
- States: IDLE, REQ, ADDR, WDATA, WAIT_ACK, RDATA, DONE.
- IDLE: init_req=1 at an edge latches addr/wdata/rw -> REQ. init_req in any other state is ignored.
- REQ: bus_req=1. bus_grant=1 -> ADDR. No timeout in REQ.
- ADDR: 16 cycles, counter k=0..15; bus_data_out=addr[k], valid=1, bus_mode=0. After k=15: write -> WDATA, read -> RDATA.
- WDATA: 8 cycles, bus_data_out=wdata[k], valid=1, bus_mode=1 -> WAIT_ACK.
- WAIT_ACK: valid=0, bus_mode=1. bus_target_ack=1 -> DONE (ok). TIMEOUT cycles without ack -> DONE (error).
- RDATA: valid=0, bus_mode=1. Each cycle with bus_data_in_valid=1 stores the bit at position j (LSB first, j=0..7) and resets the timeout counter. When the 8th bit arrives -> DONE (ok), and init_rdata updates. TIMEOUT consecutive cycles without a bit -> DONE (error), and init_rdata is unchanged.
- DONE: one cycle. init_done=1, bus_req=0, error/rdata_valid as decided -> IDLE.
- bus_mode stays 1 from the first WDATA/RDATA cycle through DONE, so the target never sees an address-mode idle while its address is pending. It is 0 in IDLE/REQ/ADDR.
- Grant loss: bus_grant=0 in ADDR/WDATA/WAIT_ACK/RDATA -> DONE with error the next cycle; serialization stops immediately.
- bus_data_out is 0 whenever valid=0.

## Timing
- All outputs registered and decoded from state plus counters. Reset values: every output 0, init_rdata=0x00, state IDLE.
- Accept at edge E0 -> REQ (bus_req=1) in cycle E0+1. Grant sampled high at edge Eg -> first address bit in cycle Eg+1.
- Write, grant held: 16 + 8 consecutive valid cycles, no gaps. At least 1 WAIT_ACK cycle. Ack sampled at edge Ea -> init_done in cycle Ea+1.
- Read: 8th bit sampled at edge Eb -> init_done, init_rdata_valid and new init_rdata all in cycle Eb+1.
- Timeout: counter starts at 0 on entry. Error when it reaches TIMEOUT, so DONE comes exactly TIMEOUT+1 cycles after entry if there is no event.
- Ack and grant loss in the same WAIT_ACK cycle: ack wins, and the transaction succeeds.
- Read bit and grant loss in the same cycle: error wins.
- Back-to-back: init_req held high re-accepts in the IDLE cycle after DONE, giving a minimum of 2 cycles from init_done to the next bus_req.
- Reset mid-transaction: all outputs drop to reset values asynchronously. No init_done is issued. Latched transaction is discarded.

## Test plan
- Write 0x1234/0xA5, grant immediate, ack 3 cycles after last data bit -> bus_data_out sequence 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 (mode 0) then 1,0,1,0,0,1,0,1 (mode 1); init_done=1, init_error=0.
- Read 0x00F0, target returns 0x3C with gaps of 2 cycles between bits -> 16 address bits; init_rdata=0x3C, init_rdata_valid=1 in the cycle after the 8th bit.
- Write with no ack, TIMEOUT=4 -> init_done and init_error in cycle 5 after WAIT_ACK entry; bus_req=0 in that cycle.
- Grant delayed 10 cycles, second init_req pulse while busy -> no bus activity until grant; exactly one transaction completes.
- Grant dropped at address bit 7 -> valid=0 from the next cycle; init_done=1 and init_error=1.
- rst asserted during WDATA bit 3 -> all outputs 0 at once; after release, a new read of 0x0001 completes normally.
